vio_route_stage: RTL and testbench
==================================

# vio_route_stage

Per-region routing stage placed directly upstream of the vFPGA data switch on the user-logic (DTU) side. For every vFPGA region it takes the user's outbound AXI4SR stream and drives the switch's DTU sink port. It also supplies the matching 14-bit route (switch tdest) for that port. Routes are reprogrammed through a simple write port and take effect only at packet boundaries, so a packet is never split across destinations.

## Interface
- N_ID, default N_REGIONS: number of vFPGA regions (1..16).
- ROUTE_BITS, package constant 14: route/tdest width.
- aclk  in  1: clock; all logic rising-edge.
- aresetn  in  1: reset, synchronous, active-low.
- route_wr_valid  in  1: route write strobe.
- route_wr_id  in  4: target region.
- route_wr_data  in  ROUTE_BITS: new route.
- route_in  out  [N_ID][ROUTE_BITS]: route of the beat currently presented on data_sw_src[i]; drives the switch route input.
- route_busy  out  [N_ID]: region i is mid-packet (at least one non-last beat accepted, tlast not yet accepted).
- data_user_sink  AXI4SR.s  [N_ID]: stream from user logic (tdata AXI_DATA_BITS, tkeep, tlast, tid PID_BITS).
- data_sw_src  AXI4SR.m  [N_ID]: stream to the switch DTU sink.
- pkt_cnt  out  [N_ID][32]: present only with VIO_ROUTE_STATS_EN.

## Operation
- Per region, three route registers:
  - active: the route used for the current packet.
  - shadow: the last written route.
  - pend: a flag meaning shadow has not yet been applied.
- Reset values:
  - active = ROUTE_HOST(i) = {i[3:0], 10'b1111111100}, the host port of the same region.
  - shadow = ROUTE_HOST(i); pend = 0; in_pkt = 0.
- Route write: when route_wr_valid and route_wr_id < N_ID:
  - shadow[id] <= route_wr_data; pend[id] <= 1.
  - Writes with id >= N_ID are ignored.
  - Back-to-back writes to the same region: the last one wins.
- Packet start (input beat accepted while in_pkt = 0):
  - If pend, then active <= shadow and pend <= 0.
  - The beat is tagged with the resulting active value.
- Continuation beats (in_pkt = 1) are tagged with active unchanged.
- in_pkt tracking:
  - Set on an accepted beat with tlast = 0.
  - Cleared on an accepted beat with tlast = 1.
  - A single-beat packet leaves it at 0.
- A write in the same cycle as a packet-start beat:
  - The beat uses the previous shadow/active.
  - The new write sets pend and applies at the next packet start.
- tdata, tkeep, tlast and tid pass through unchanged. route_in[i] always equals the tag of the beat at the output head.
- route_busy[i] = in_pkt[i].

## Timing
- Per-region 2-entry register slice (main + skid).
- Latency: 1 cycle input-accept to output-valid.
- Throughput: full rate, one beat per cycle per region when the switch holds tready high.
- data_user_sink.tready is registered: tready = skid entry empty.
- Output rules:
  - tvalid, tdata, tkeep, tlast, tid and route_in hold stable while tvalid && !tready.
  - No combinational path from data_sw_src.tready to data_user_sink.tready.
- Values during reset (aresetn = 0) and the first cycle after release:
  - data_user_sink.tready = 0, data_sw_src.tvalid = 0.
  - route_in = ROUTE_HOST(i), route_busy = 0, pkt_cnt = 0.
  - tready rises on the first cycle after reset release.
- Reset mid-packet discards any buffered beats and clears in_pkt and pend. The next beat is treated as a packet start.
- Regions are fully independent; no cross-region arbitration.

## Configuration
- VIO_ROUTE_STATS_EN defined:
  - pkt_cnt[i] increments on each output beat with tvalid && tready && tlast.
  - The 32-bit counter wraps 0xFFFFFFFF -> 0.
  - Reset value 0.
- Not defined: the pkt_cnt port and its counters are absent; all other behaviour is identical.

## Structure
- lynxTypes package holds:
  - ROUTE_BITS = 14.
  - function ROUTE_HOST(region) returning {region[3:0], 10'b1111111100}.
  - typedef route_t = logic [ROUTE_BITS-1:0].
- Sub-module vio_route_lane: one region containing the route registers, in_pkt and the register slice (plus the counter under the macro).
- The top level generates N_ID lanes and decodes route_wr_id to per-lane write enables.

## Test plan
- Reset, then a 4-beat packet on region 3 with no writes -> route_in[3] = 14'b00111111111100 on all 4 beats, 1-cycle latency.
- Write 14'h0004 to region 2 after beat 2 of a 5-beat packet -> beats 3–5 keep the old route; the next packet carries 14'h0004 and pend clears.
- Write in the same cycle as a first beat on region 1 -> that packet uses the old route; the following packet uses the new one.
- Hold data_sw_src[0].tready low 10 cycles during a stream:
  - Input tready drops after 2 buffered beats.
  - Output and route hold stable.
  - No beat is lost or duplicated; order is preserved.
- Write with route_wr_id = N_ID -> no region changes route.
- Reset asserted mid-packet, then a new packet -> the new packet is routed with the reset route, and route_busy = 0 after reset. With VIO_ROUTE_STATS_EN:
  - Counter preloaded (forced) near 0xFFFFFFFF, then 2 packets -> pkt_cnt wraps to 0x00000000.
  - pkt_cnt = 0 after reset.

Source files
------------

// File: rtl/vio_route_stage_pkg.sv
// Shared types and constants for the per-region route stage.
package vio_route_stage_pkg;

  localparam int ROUTE_BITS    = 14;
  localparam int N_REGIONS     = 4;
  localparam int AXI_DATA_BITS = 64;
  localparam int AXI_KEEP_BITS = AXI_DATA_BITS / 8;
  localparam int PID_BITS      = 6;

  typedef logic [ROUTE_BITS-1:0] route_t;

  // One buffered beat, carrying the route it was tagged with on entry.
  typedef struct packed {
    logic [AXI_DATA_BITS-1:0] tdata;
    logic [AXI_KEEP_BITS-1:0] tkeep;
    logic                     tlast;
    logic [PID_BITS-1:0]      tid;
    route_t                   route;
  } beat_t;

  // Host port of a region: region number in the top nibble, fixed host tag below.
  function automatic route_t ROUTE_HOST(input logic [3:0] region);
    return {region, 10'b1111111100};
  endfunction

endpackage

// File: rtl/vio_route_stage_lane.sv
// One region: active/shadow/pend route registers, packet tracking and a
// 2-entry register slice (main + skid). With VIO_ROUTE_STATS_EN defined the
// lane also counts packets leaving on the output side.
module vio_route_stage_lane
  import vio_route_stage_pkg::*;
#(
  parameter logic [3:0] REGION_ID = 4'd0
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic                     wr_en,
  input  route_t                   wr_data,
  input  logic                     in_tvalid,
  output logic                     in_tready,
  input  logic [AXI_DATA_BITS-1:0] in_tdata,
  input  logic [AXI_KEEP_BITS-1:0] in_tkeep,
  input  logic                     in_tlast,
  input  logic [PID_BITS-1:0]      in_tid,
  output logic                     out_tvalid,
  input  logic                     out_tready,
  output logic [AXI_DATA_BITS-1:0] out_tdata,
  output logic [AXI_KEEP_BITS-1:0] out_tkeep,
  output logic                     out_tlast,
  output logic [PID_BITS-1:0]      out_tid,
  output route_t                   route_out,
`ifdef VIO_ROUTE_STATS_EN
  output logic [31:0]              pkt_cnt,
`endif
  output logic                     busy
);

  route_t active_q, shadow_q;
  logic   pend_q, in_pkt_q;
  beat_t  main_q, skid_q, in_beat;
  logic   main_vld_q, skid_vld_q, rdy_q, skid_vld_nxt;
  logic   accept;
  route_t tag;

  assign accept = in_tvalid && rdy_q;
  // A pending route is only adopted by the first beat of a packet.
  assign tag    = (!in_pkt_q && pend_q) ? shadow_q : active_q;

  // Incoming beat together with its route tag.
  always_comb begin
    in_beat = '{tdata: in_tdata, tkeep: in_tkeep, tlast: in_tlast, tid: in_tid, route: tag};
  end

  // Route registers and packet tracking; a write in the same cycle as a
  // packet start still sets pend, so it lands on the following packet.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      active_q <= ROUTE_HOST(REGION_ID);
      shadow_q <= ROUTE_HOST(REGION_ID);
      pend_q   <= 1'b0;
      in_pkt_q <= 1'b0;
    end else begin
      if (accept) begin
        if (!in_pkt_q && pend_q) begin
          active_q <= shadow_q;
          pend_q   <= 1'b0;
        end
        in_pkt_q <= !in_tlast;
      end
      if (wr_en) begin
        shadow_q <= wr_data;
        pend_q   <= 1'b1;
      end
    end
  end

  // Skid occupancy next cycle: drains whenever main frees up, fills when main is held.
  always_comb begin
    skid_vld_nxt = skid_vld_q;
    if (!main_vld_q || out_tready) skid_vld_nxt = 1'b0;
    else if (accept)               skid_vld_nxt = 1'b1;
  end

  // Main entry and registered input ready (low through reset and the release cycle).
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      main_vld_q <= 1'b0;
      skid_vld_q <= 1'b0;
      rdy_q      <= 1'b0;
      main_q     <= '{tdata: '0, tkeep: '0, tlast: 1'b0, tid: '0, route: ROUTE_HOST(REGION_ID)};
    end else begin
      rdy_q      <= !skid_vld_nxt;
      skid_vld_q <= skid_vld_nxt;
      if (!main_vld_q || out_tready) begin
        if (skid_vld_q) begin
          main_q     <= skid_q;
          main_vld_q <= 1'b1;
        end else begin
          main_vld_q <= accept;
          if (accept) main_q <= in_beat;
        end
      end
    end
  end

  // Skid data only captures while main is stalled; its valid bit guards it.
  always_ff @(posedge aclk) begin
    if (main_vld_q && !out_tready && accept) skid_q <= in_beat;
  end

`ifdef VIO_ROUTE_STATS_EN
  logic [31:0] pkt_cnt_q;
  // Packets counted as their last beat leaves; wraps naturally.
  always_ff @(posedge aclk) begin
    if (!aresetn) pkt_cnt_q <= '0;
    else if (main_vld_q && out_tready && main_q.tlast) pkt_cnt_q <= pkt_cnt_q + 32'd1;
  end
  assign pkt_cnt = pkt_cnt_q;
`endif

  assign in_tready  = rdy_q;
  assign out_tvalid = main_vld_q;
  assign out_tdata  = main_q.tdata;
  assign out_tkeep  = main_q.tkeep;
  assign out_tlast  = main_q.tlast;
  assign out_tid    = main_q.tid;
  assign route_out  = main_q.route;
  assign busy       = in_pkt_q;

endmodule

// File: rtl/vio_route_stage.sv
// Per-region route stage in front of the vFPGA data switch. Each region gets
// its own lane; route writes are decoded to one lane by route_wr_id, ids
// beyond N_ID match no lane. VIO_ROUTE_STATS_EN adds per-region pkt_cnt.
module vio_route_stage
  import vio_route_stage_pkg::*;
#(
  parameter int N_ID = N_REGIONS
) (
  input  logic                                   aclk,
  input  logic                                   aresetn,
  input  logic                                   route_wr_valid,
  input  logic [3:0]                             route_wr_id,
  input  route_t                                 route_wr_data,
  output route_t [N_ID-1:0]                      route_in,
  output logic   [N_ID-1:0]                      route_busy,
  input  logic   [N_ID-1:0]                      data_user_sink_tvalid,
  output logic   [N_ID-1:0]                      data_user_sink_tready,
  input  logic   [N_ID-1:0][AXI_DATA_BITS-1:0]   data_user_sink_tdata,
  input  logic   [N_ID-1:0][AXI_KEEP_BITS-1:0]   data_user_sink_tkeep,
  input  logic   [N_ID-1:0]                      data_user_sink_tlast,
  input  logic   [N_ID-1:0][PID_BITS-1:0]        data_user_sink_tid,
  output logic   [N_ID-1:0]                      data_sw_src_tvalid,
  input  logic   [N_ID-1:0]                      data_sw_src_tready,
  output logic   [N_ID-1:0][AXI_DATA_BITS-1:0]   data_sw_src_tdata,
  output logic   [N_ID-1:0][AXI_KEEP_BITS-1:0]   data_sw_src_tkeep,
  output logic   [N_ID-1:0]                      data_sw_src_tlast,
`ifdef VIO_ROUTE_STATS_EN
  output logic   [N_ID-1:0][31:0]                pkt_cnt,
`endif
  output logic   [N_ID-1:0][PID_BITS-1:0]        data_sw_src_tid
);

  // One independent lane per region.
  for (genvar i = 0; i < N_ID; i++) begin : g_lane
    vio_route_stage_lane #(.REGION_ID(4'(i))) u_lane (
      .aclk       (aclk),
      .aresetn    (aresetn),
      .wr_en      (route_wr_valid && (route_wr_id == 4'(i))),
      .wr_data    (route_wr_data),
      .in_tvalid  (data_user_sink_tvalid[i]),
      .in_tready  (data_user_sink_tready[i]),
      .in_tdata   (data_user_sink_tdata[i]),
      .in_tkeep   (data_user_sink_tkeep[i]),
      .in_tlast   (data_user_sink_tlast[i]),
      .in_tid     (data_user_sink_tid[i]),
      .out_tvalid (data_sw_src_tvalid[i]),
      .out_tready (data_sw_src_tready[i]),
      .out_tdata  (data_sw_src_tdata[i]),
      .out_tkeep  (data_sw_src_tkeep[i]),
      .out_tlast  (data_sw_src_tlast[i]),
      .out_tid    (data_sw_src_tid[i]),
      .route_out  (route_in[i]),
`ifdef VIO_ROUTE_STATS_EN
      .pkt_cnt    (pkt_cnt[i]),
`endif
      .busy       (route_busy[i])
    );
  end

endmodule

// File: tb/tb_vio_route_stage.sv
// Scoreboard bench for vio_route_stage: directed scenarios plus random traffic
// against a packet-level route model.
module tb_vio_route_stage;
  import vio_route_stage_pkg::*;

  localparam int N = N_REGIONS;

  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  always #5 aclk = ~aclk;

  logic                route_wr_valid = 1'b0;
  logic [3:0]          route_wr_id = '0;
  route_t              route_wr_data = '0;
  route_t [N-1:0]      route_in;
  logic [N-1:0]        route_busy;
  logic [N-1:0]        u_tvalid = '0, u_tready, u_tlast = '0;
  logic [N-1:0][63:0]  u_tdata = '0;
  logic [N-1:0][7:0]   u_tkeep = '0;
  logic [N-1:0][5:0]   u_tid = '0;
  logic [N-1:0]        s_tvalid, s_tready = '1, s_tlast;
  logic [N-1:0][63:0]  s_tdata;
  logic [N-1:0][7:0]   s_tkeep;
  logic [N-1:0][5:0]   s_tid;
`ifdef VIO_ROUTE_STATS_EN
  logic [N-1:0][31:0]  pkt_cnt;
`endif

  vio_route_stage #(.N_ID(N)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .route_wr_valid(route_wr_valid), .route_wr_id(route_wr_id), .route_wr_data(route_wr_data),
    .route_in(route_in), .route_busy(route_busy),
    .data_user_sink_tvalid(u_tvalid), .data_user_sink_tready(u_tready),
    .data_user_sink_tdata(u_tdata), .data_user_sink_tkeep(u_tkeep),
    .data_user_sink_tlast(u_tlast), .data_user_sink_tid(u_tid),
    .data_sw_src_tvalid(s_tvalid), .data_sw_src_tready(s_tready),
    .data_sw_src_tdata(s_tdata), .data_sw_src_tkeep(s_tkeep),
    .data_sw_src_tlast(s_tlast),
`ifdef VIO_ROUTE_STATS_EN
    .pkt_cnt(pkt_cnt),
`endif
    .data_sw_src_tid(s_tid)
  );

  int total = 0;
  int bad = 0;

  // Reference model: route each region will stamp on its next packet.
  route_t m_active [N];
  route_t m_shadow [N];
  bit     m_pend   [N];
  bit     m_in_pkt [N];
  beat_t  sb [N][$];
  route_t mon_last_route [N];

  logic [N-1:0] acc_mask = '0, prev_acc = '0;
  bit     chk_lat = 0;
  route_t lat_route = '0;

  function automatic void chk(string name, logic [127:0] act, logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < N; i++) begin
      m_active[i] = ROUTE_HOST(4'(i));
      m_shadow[i] = ROUTE_HOST(4'(i));
      m_pend[i]   = 0;
      m_in_pkt[i] = 0;
      sb[i].delete();
    end
  endfunction

  function automatic void model_accept(int i);
    beat_t b;
    if (!m_in_pkt[i] && m_pend[i]) begin
      m_active[i] = m_shadow[i];
      m_pend[i]   = 0;
    end
    b = '{tdata: u_tdata[i], tkeep: u_tkeep[i], tlast: u_tlast[i], tid: u_tid[i], route: m_active[i]};
    sb[i].push_back(b);
    m_in_pkt[i] = !u_tlast[i];
  endfunction

  // Monitor: every beat the switch takes is popped and compared.
  always @(negedge aclk) begin
    if (aresetn === 1'b1) begin
      for (int i = 0; i < N; i++) begin
        if (s_tvalid[i] && s_tready[i]) begin
          if (sb[i].size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_beat: region %0d got route %0h expected no beat", i, route_in[i]);
          end else begin
            beat_t e, g;
            e = sb[i].pop_front();
            g = '{tdata: s_tdata[i], tkeep: s_tkeep[i], tlast: s_tlast[i], tid: s_tid[i], route: route_in[i]};
            chk($sformatf("beat_r%0d", i), 128'(g), 128'(e));
            mon_last_route[i] = route_in[i];
          end
        end
      end
    end
  end

  // One clock: check, record accepts/writes in the model at negedge, return at posedge+1.
  task automatic cycle();
    @(negedge aclk);
    for (int i = 0; i < N; i++) begin
      chk($sformatf("busy_r%0d", i), 128'(route_busy[i]), 128'(m_in_pkt[i]));
      if (chk_lat && prev_acc[i]) begin
        chk("latency_valid", 128'(s_tvalid[i]), 128'(1));
        chk("latency_route", 128'(route_in[i]), 128'(lat_route));
      end
    end
    acc_mask = '0;
    for (int i = 0; i < N; i++) begin
      if (u_tvalid[i] && u_tready[i]) begin
        acc_mask[i] = 1'b1;
        model_accept(i);
      end
    end
    if (route_wr_valid && route_wr_id < N) begin
      m_shadow[route_wr_id] = route_wr_data;
      m_pend[route_wr_id]   = 1;
    end
    prev_acc = acc_mask;
    @(posedge aclk);
    #1;
  endtask

  task automatic set_beat(int i, logic last);
    u_tvalid[i] = 1'b1;
    u_tdata[i]  = {$urandom(), $urandom()};
    u_tkeep[i]  = 8'($urandom());
    u_tlast[i]  = last;
    u_tid[i]    = 6'($urandom());
  endtask

  // Sends len beats on region r; write wr_d in the cycle beat wr_at is offered.
  task automatic send_pkt(int r, int len, int wr_at, route_t wr_d, bit close);
    for (int b = 0; b < len; b++) begin
      int t;
      set_beat(r, close && (b == len - 1));
      if (b == wr_at) begin
        route_wr_valid = 1'b1;
        route_wr_id    = 4'(r);
        route_wr_data  = wr_d;
      end
      t = 0;
      do begin
        cycle();
        route_wr_valid = 1'b0;
        t++;
      end while (!acc_mask[r] && t < 50);
      chk("send_accept", 128'(acc_mask[r]), 128'(1));
    end
    u_tvalid[r] = 1'b0;
  endtask

  task automatic drain();
    int t, left;
    u_tvalid = '0;
    s_tready = '1;
    t = 0;
    do begin
      left = 0;
      for (int i = 0; i < N; i++) left += sb[i].size();
      if (left != 0) cycle();
      t++;
    end while (left != 0 && t < 100);
    chk("drain_pending", 128'(left), 128'(0));
  endtask

  task automatic do_reset();
    aresetn = 1'b0;
    u_tvalid = '0;
    route_wr_valid = 1'b0;
    model_reset();
    repeat (2) @(posedge aclk);
    @(negedge aclk);
    for (int i = 0; i < N; i++) begin
      chk("rst_in_tready", 128'(u_tready[i]), 128'(0));
      chk("rst_out_tvalid", 128'(s_tvalid[i]), 128'(0));
      chk("rst_route_in", 128'(route_in[i]), 128'(ROUTE_HOST(4'(i))));
      chk("rst_busy", 128'(route_busy[i]), 128'(0));
`ifdef VIO_ROUTE_STATS_EN
      chk("rst_pkt_cnt", 128'(pkt_cnt[i]), 128'(0));
`endif
    end
    @(posedge aclk);
    #1;
    aresetn = 1'b1;
    @(negedge aclk);
    for (int i = 0; i < N; i++) begin
      chk("release_tready_low", 128'(u_tready[i]), 128'(0));
      chk("release_tvalid_low", 128'(s_tvalid[i]), 128'(0));
    end
    @(posedge aclk);
    #1;
    @(negedge aclk);
    for (int i = 0; i < N; i++) chk("release_tready_up", 128'(u_tready[i]), 128'(1));
    @(posedge aclk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int accd, more, t;
    bit have_snap;
    logic [127:0] snap, cur;
    route_t exp5 [N];

    do_reset();

    // Region 3, 4 beats, no writes: host route, 1-cycle latency.
    chk_lat = 1;
    lat_route = 14'b00111111111100;
    send_pkt(3, 4, -1, '0, 1);
    cycle();
    chk_lat = 0;
    drain();
    chk("t1_route", 128'(mon_last_route[3]), 128'(14'b00111111111100));

    // Region 2: write mid-packet only affects the next packet.
    send_pkt(2, 5, 2, 14'h0004, 1);
    drain();
    chk("t2_old_route", 128'(mon_last_route[2]), 128'(ROUTE_HOST(4'd2)));
    send_pkt(2, 2, -1, '0, 1);
    drain();
    chk("t2_new_route", 128'(mon_last_route[2]), 128'(14'h0004));

    // Region 1: write in the same cycle as the first beat.
    send_pkt(1, 3, 0, 14'h0aaa, 1);
    drain();
    chk("t3_old_route", 128'(mon_last_route[1]), 128'(ROUTE_HOST(4'd1)));
    send_pkt(1, 2, -1, '0, 1);
    drain();
    chk("t3_new_route", 128'(mon_last_route[1]), 128'(14'h0aaa));

    // Region 0: 10-cycle output stall while the user keeps streaming.
    s_tready[0] = 1'b0;
    accd = 0;
    have_snap = 0;
    snap = '0;
    set_beat(0, 1'b0);
    for (int c = 0; c < 10; c++) begin
      cycle();
      if (acc_mask[0]) begin
        accd++;
        set_beat(0, 1'b0);
      end
      cur = 128'({s_tvalid[0], s_tdata[0], s_tkeep[0], s_tlast[0], s_tid[0], route_in[0]});
      if (s_tvalid[0]) begin
        if (!have_snap) begin
          snap = cur;
          have_snap = 1;
        end else chk("stall_hold", cur, snap);
      end
    end
    chk("stall_accepts", 128'(accd), 128'(2));
    chk("stall_in_tready", 128'(u_tready[0]), 128'(0));
    s_tready[0] = 1'b1;
    more = 0;
    t = 0;
    while (more < 6 && t < 100) begin
      cycle();
      t++;
      if (acc_mask[0]) begin
        more++;
        if (more < 5) set_beat(0, 1'b0);
        else if (more == 5) set_beat(0, 1'b1);
        else u_tvalid[0] = 1'b0;
      end
    end
    chk("stall_resume", 128'(more), 128'(6));
    drain();

    // Out-of-range ids change nothing.
    route_wr_valid = 1'b1;
    route_wr_id = 4'(N);
    route_wr_data = 14'h1555;
    cycle();
    route_wr_id = 4'd15;
    cycle();
    route_wr_valid = 1'b0;
    exp5[0] = ROUTE_HOST(4'd0);
    exp5[1] = 14'h0aaa;
    exp5[2] = 14'h0004;
    exp5[3] = ROUTE_HOST(4'd3);
    for (int i = 0; i < N; i++) begin
      send_pkt(i, 1, -1, '0, 1);
      drain();
      chk($sformatf("t5_route_r%0d", i), 128'(mon_last_route[i]), 128'(exp5[i]));
    end

    // Random traffic, backpressure and writes (including invalid ids).
    acc_mask = '0;
    u_tvalid = '0;
    for (int c = 0; c < 1500; c++) begin
      s_tready = N'($urandom());
      for (int i = 0; i < N; i++) begin
        if (!u_tvalid[i] || acc_mask[i]) begin
          if ($urandom_range(0, 3) != 0) set_beat(i, $urandom_range(0, 3) == 0);
          else u_tvalid[i] = 1'b0;
        end
      end
      route_wr_valid = ($urandom_range(0, 7) == 0);
      route_wr_id    = 4'($urandom_range(0, 5));
      route_wr_data  = 14'($urandom());
      cycle();
    end
    route_wr_valid = 1'b0;
    drain();

    // Mid-packet reset on region 1 after a non-host route is in use.
    send_pkt(1, 1, 0, 14'h0123, 1);
    send_pkt(1, 1, -1, '0, 1);
    drain();
    chk("t6_pre_route", 128'(mon_last_route[1]), 128'(14'h0123));
    send_pkt(1, 2, -1, '0, 0);
    cycle();
    chk("t6_busy_mid", 128'(route_busy[1]), 128'(1));
    do_reset();
    chk("t6_busy_after", 128'(route_busy[1]), 128'(0));
    send_pkt(1, 3, -1, '0, 1);
    drain();
    chk("t6_route_after", 128'(mon_last_route[1]), 128'(ROUTE_HOST(4'd1)));

`ifdef VIO_ROUTE_STATS_EN
    force dut.g_lane[0].u_lane.pkt_cnt_q = 32'hFFFF_FFFE;
    #1;
    release dut.g_lane[0].u_lane.pkt_cnt_q;
    send_pkt(0, 2, -1, '0, 1);
    send_pkt(0, 1, -1, '0, 1);
    drain();
    chk("pkt_cnt_wrap", 128'(pkt_cnt[0]), 128'(0));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
